// File: rtl/xain_audio_mix.sv
// Xain'd Sleena two-channel audio mixer: capture, attenuate/mute, sum, optional DC block,
// saturate to 16 bits and queue in a show-ahead FIFO. Define XAIN_AUDIO_DCBLOCK_EN for the DC blocker.
module xain_audio_mix #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic [15:0] snd1,
   input  logic [15:0] snd2,
   input  logic        sample_stb,
   input  logic [2:0]  vol1,
   input  logic [2:0]  vol2,
   input  logic        mute,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        ovf,
   input  logic        ovf_clr
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   function automatic logic signed [15:0] sat16(input logic signed [19:0] x);
      if (x > 20'sd32767)
         return 16'sh7fff;
      else if (x < -20'sd32768)
         return 16'sh8000;
      else
         return x[15:0];
   endfunction

   logic signed [17:0] snd1_p0_q, snd2_p0_q;
   logic               vld_p0_q;
   logic signed [17:0] a1_p1, a2_p1, mix_p1_d, mix_p1_q;
   logic               vld_p1_q;
   logic signed [19:0] dc_p2;
   logic signed [15:0] smp_p2;

   // S0: capture
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         vld_p0_q  <= 1'b0;
         snd1_p0_q <= '0;
         snd2_p0_q <= '0;
      end else begin
         vld_p0_q <= sample_stb;
         if (sample_stb) begin
            snd1_p0_q <= {{2{snd1[15]}}, snd1};
            snd2_p0_q <= {{2{snd2[15]}}, snd2};
         end
      end
   end

   // S1: attenuate, mute and sum
   always_comb begin
      a1_p1    = snd1_p0_q >>> vol1;
      a2_p1    = snd2_p0_q >>> vol2;
      mix_p1_d = mute ? 18'sd0 : a1_p1 + a2_p1;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         vld_p1_q <= 1'b0;
         mix_p1_q <= '0;
      end else begin
         vld_p1_q <= vld_p0_q;
         mix_p1_q <= mix_p1_d;
      end
   end

   // S2: DC stage, evaluated in the same cycle as the FIFO write to keep latency at three edges
`ifdef XAIN_AUDIO_DCBLOCK_EN
   function automatic logic signed [27:0] clamp_y(input logic signed [29:0] x);
      if (x > 30'sd134217727)
         return 28'sh7ffffff;
      else if (x < -30'sd134217727)
         return 28'sh8000001;
      else
         return x[27:0];
   endfunction

   logic signed [17:0] mix_prev_q;
   logic signed [27:0] y_q, y_d;
   logic signed [29:0] mix_x, prev_x, y_x, y_sum;

   always_comb begin
      mix_x  = {{12{mix_p1_q[17]}}, mix_p1_q};
      prev_x = {{12{mix_prev_q[17]}}, mix_prev_q};
      y_x    = {{2{y_q[27]}}, y_q};
      y_sum  = ((mix_x - prev_x) <<< 8) + y_x - (y_x >>> 8);
      y_d    = clamp_y(y_sum);
      dc_p2  = 20'(y_d >>> 8);
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         mix_prev_q <= '0;
         y_q        <= '0;
      end else if (vld_p1_q) begin
         mix_prev_q <= mix_p1_q;
         y_q        <= y_d;
      end
   end
`else
   always_comb dc_p2 = {{2{mix_p1_q[17]}}, mix_p1_q};
`endif

   // S3: saturate and push into the FIFO
   always_comb smp_p2 = sat16(dc_p2);

   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          push, pop, full, wr_en, drop;

   always_comb begin
      push  = vld_p1_q;
      pop   = (cnt_q != '0) & out_ready;
      full  = (cnt_q == FULL_CNT);
      wr_en = push & (~full | pop);
      drop  = push & full & ~pop;
      cnt_d = cnt_q;
      if (wr_en & ~pop)
         cnt_d = cnt_q + 1'b1;
      else if (pop & ~wr_en)
         cnt_d = cnt_q - 1'b1;
      ovf_d = ovf_q;
      if (drop)
         ovf_d = 1'b1;
      else if (ovf_clr)
         ovf_d = 1'b0;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= smp_p2;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = (cnt_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_xain_audio_mix.sv
// Self-checking bench for xain_audio_mix: queue-based reference model plus directed literal cases.
// The DC-blocker section is active when XAIN_AUDIO_DCBLOCK_EN is defined.
module tb_xain_audio_mix;
   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic [15:0] snd1 = '0, snd2 = '0;
   logic        sample_stb = 1'b0;
   logic [2:0]  vol1 = '0, vol2 = '0;
   logic        mute = 1'b0;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        ovf;
   logic        ovf_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   xain_audio_mix #(.FIFO_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RSTn(RSTn), .snd1(snd1), .snd2(snd2), .sample_stb(sample_stb),
      .vol1(vol1), .vol2(vol2), .mute(mute), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int mix(input int s1, input int s2, input int v1, input int v2, input bit mu);
      if (mu) return 0;
      return (s1 >>> v1) + (s2 >>> v2);
   endfunction

   function automatic int sat(input longint x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return int'(x);
   endfunction

   // Reference model: a sample strobed in cycle N joins the output queue on the third edge after.
   int     q[$];
   int     dl_v[2];
   bit     dl_f[2];
   bit     m_ovf;
   longint y_m;
   int     mprev_m;

   always @(posedge CLK or negedge RSTn) begin
      bit pop, pf, drop;
      int pv, d;
      if (!RSTn) begin
         q.delete();
         dl_f[0] = 0; dl_f[1] = 0;
         dl_v[0] = 0; dl_v[1] = 0;
         m_ovf = 0; y_m = 0; mprev_m = 0;
      end else begin
         pop = (q.size() > 0) && out_ready;
         pf = dl_f[1];
         pv = dl_v[1];
         dl_f[1] = dl_f[0];
         dl_v[1] = dl_v[0];
         dl_f[0] = sample_stb;
         dl_v[0] = mix($signed(snd1), $signed(snd2), vol1, vol2, mute);
         if (pop) void'(q.pop_front());
         drop = 0;
         if (pf) begin
`ifdef XAIN_AUDIO_DCBLOCK_EN
            y_m = longint'(pv - mprev_m) * 256 + y_m - (y_m >>> 8);
            if (y_m > 134217727) y_m = 134217727;
            if (y_m < -134217727) y_m = -134217727;
            mprev_m = pv;
            d = int'(y_m >>> 8);
`else
            d = pv;
`endif
            if (q.size() < DEPTH) q.push_back(sat(d));
            else drop = 1;
         end
         if (drop) m_ovf = 1;
         else if (ovf_clr) m_ovf = 0;
      end
   end

   always @(negedge CLK) begin
      chk("out_valid", out_valid, (q.size() > 0) ? 1 : 0);
      chk("out_data", $signed(out_data), (q.size() > 0) ? q[0] : 0);
      chk("ovf", ovf, m_ovf);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic mix_check(input string name, input int s1, input int s2,
                            input int v1, input int v2, input bit mu, input int exp);
      tick();
      snd1 = s1[15:0]; snd2 = s2[15:0];
      vol1 = v1[2:0];  vol2 = v2[2:0];
      mute = mu; out_ready = 1'b1; sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      tick();
      @(negedge CLK);
      chk({name, "_early"}, out_valid, 0);
      tick();
      @(negedge CLK);
      chk({name, "_valid"}, out_valid, 1);
      chk({name, "_data"}, $signed(out_data), exp);
      tick();
      @(negedge CLK);
      chk({name, "_once"}, out_valid, 0);
   endtask

   int arr[2048];

   initial begin
      // reset held with random inputs
      RSTn = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         snd1 = 16'($urandom); snd2 = 16'($urandom);
         sample_stb = 1'($urandom); vol1 = 3'($urandom); vol2 = 3'($urandom);
         mute = 1'($urandom); out_ready = 1'($urandom); ovf_clr = 1'($urandom);
      end
      @(negedge CLK);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_ovf", ovf, 0);
      tick();
      sample_stb = 1'b0; vol1 = '0; vol2 = '0; mute = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
      RSTn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("idle_valid", out_valid, 0);
         tick();
      end

`ifndef XAIN_AUDIO_DCBLOCK_EN
      mix_check("sum", 1000, 2000, 0, 0, 0, 3000);
      mix_check("sat_pos", 30000, 30000, 0, 0, 0, 32767);
      mix_check("sat_neg", -30000, -30000, 0, 0, 0, -32768);
      mix_check("mute", 12345, -777, 3, 1, 1, 0);
      mix_check("atten", -1000, 1280, 2, 7, 0, -240);

      // overflow: five strobes into a four-entry FIFO with the consumer stalled
      tick();
      out_ready = 1'b0; mute = 1'b0; vol1 = '0; vol2 = '0;
      for (int i = 1; i <= 5; i++) begin
         snd1 = 16'(i); snd2 = '0; sample_stb = 1'b1;
         tick();
      end
      sample_stb = 1'b0;
      repeat (3) tick();
      @(negedge CLK);
      chk("ovf_set", ovf, 1);
      chk("ovf_valid", out_valid, 1);
      chk("ovf_head", $signed(out_data), 1);
      tick();
      out_ready = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(negedge CLK);
         chk("drain_data", $signed(out_data), e);
         tick();
      end
      @(negedge CLK);
      chk("drain_empty", out_valid, 0);
      chk("ovf_sticky", ovf, 1);
      tick();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      @(negedge CLK);
      chk("ovf_clr", ovf, 0);
`endif

      // randomized traffic; attenuation and mute change only while the pipeline is idle
      for (int blk = 0; blk < 30; blk++) begin
         tick();
         sample_stb = 1'b0;
         vol1 = 3'($urandom); vol2 = 3'($urandom);
         mute = ($urandom_range(7) == 0);
         for (int c = 0; c < 40; c++) begin
            tick();
            sample_stb = ($urandom_range(9) < 6);
            snd1 = 16'($urandom); snd2 = 16'($urandom);
            out_ready = (blk % 5 == 0) ? ($urandom_range(4) == 0) : ($urandom_range(3) != 0);
            ovf_clr = ($urandom_range(15) == 0);
            if (blk == 15 && c == 20) begin
               #2;
               RSTn = 1'b0;
               #1;
               chk("midrst_valid", out_valid, 0);
               chk("midrst_ovf", ovf, 0);
               chk("midrst_data", out_data, 0);
               tick();
               RSTn = 1'b1;
            end
         end
         sample_stb = 1'b0;
         ovf_clr = 1'b0;
         repeat (3) tick();
      end

`ifdef XAIN_AUDIO_DCBLOCK_EN
      // DC step response: constant 1000 on channel 1 must decay to near zero
      begin
         int n, bad, last;
         tick();
         RSTn = 1'b0;
         tick();
         RSTn = 1'b1;
         vol1 = '0; vol2 = '0; mute = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
         n = 0;
         for (int i = 0; i < 2056; i++) begin
            if (i < 2048) begin
               snd1 = 16'd1000; snd2 = '0; sample_stb = 1'b1;
            end else begin
               sample_stb = 1'b0;
            end
            @(negedge CLK);
            if (out_valid && n < 2048) begin
               arr[n] = $signed(out_data);
               n++;
            end
            tick();
         end
         chk("dc_count", n, 2048);
         chk("dc_first", arr[0], 1000);
         chk("dc_second", arr[1], 996);
         bad = 0;
         for (int k = 1; k < 2048; k++)
            if (arr[k] > arr[k-1]) bad++;
         chk("dc_monotonic", bad, 0);
         last = (arr[2047] < 0) ? -arr[2047] : arr[2047];
         chk("dc_final_small", (last <= 1) ? 1 : 0, 1);
      end
`endif

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
